ham_minmax_engine: RTL and testbench
====================================

HAM_MINMAX_ENGINE -- requirements
Module: ham_minmax_engine

Interface
REQ-001 The block SHALL have parameter N_WORDS, default 32, giving the number of 16-bit operands scanned.
REQ-002 The block SHALL have parameter MIN_ADDR, default 64, giving the data-memory byte address receiving the minimum distance.
REQ-003 The block SHALL have parameter MAX_ADDR, default 65, giving the data-memory byte address receiving the maximum distance.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, 1 bit: high means hold/load phase; a high-to-low transition starts a run.
REQ-007 The block SHALL have port done, output, 1 bit: high when results are written and valid.
REQ-008 The block SHALL have port mem_addr, output, 8 bits: data-memory byte address.
REQ-009 The block SHALL have port mem_rdata, input, 8 bits: data-memory read data, combinational from mem_addr in the same cycle.
REQ-010 The block SHALL have port mem_wen, output, 1 bit: data-memory write enable, sampled by memory on the rising edge.
REQ-011 The block SHALL have port mem_wdata, output, 8 bits: data-memory write data, zero-extended distance.
REQ-012 The block SHALL have port min_dist, output, 5 bits: registered minimum Hamming distance.
REQ-013 The block SHALL have port max_dist, output, 5 bits: registered maximum Hamming distance.

Function
REQ-014 States SHALL be IDLE, LOAD, COMPARE, WR_MIN, WR_MAX, DONE.
REQ-015 IDLE SHALL go to LOAD at the first edge where req is sampled 0 (the start edge); it SHALL stay in IDLE while req=1.
REQ-016 LOAD SHALL take 2*N_WORDS cycles, present mem_addr = 0,1,...,2*N_WORDS-1 (one per cycle), and cache operand k = {byte[2k], byte[2k+1]}.
REQ-017 COMPARE SHALL evaluate one pair (i,j) per cycle, in the order i=0..N_WORDS-2 and j=i+1..N_WORDS-1, giving N_WORDS*(N_WORDS-1)/2 cycles (496 at default).
REQ-018 The pair distance SHALL be the 5-bit popcount of word[i] XOR word[j], range 0..16.
REQ-019 Running min SHALL start at 16 and update only on a strictly smaller distance; running max SHALL start at 0 and update only on a strictly larger distance.
REQ-020 WR_MIN SHALL drive mem_addr=MIN_ADDR, mem_wdata={3'b0,min}, mem_wen=1 for exactly one cycle; WR_MAX SHALL do the same with MAX_ADDR and max.
REQ-021 done SHALL rise exactly 2*N_WORDS + N_WORDS*(N_WORDS-1)/2 + 3 cycles after the start edge (563 at default).
REQ-022 done SHALL stay high in DONE while req=0; at the first edge with req=1, the block SHALL go to IDLE and done SHALL be 0 the next cycle.
REQ-023 In LOAD or COMPARE, req sampled 1 SHALL abort the run to IDLE with no memory writes, and min_dist/max_dist SHALL keep their prior values.
REQ-024 mem_wen SHALL be 0 in every state except WR_MIN and WR_MAX, and mem_addr SHALL be 0 in IDLE and DONE.
REQ-025 min_dist/max_dist SHALL update only at the WR_MIN/WR_MAX edges respectively.
REQ-026 A new run SHALL reinitialize the running min/max to 16/0 and ignore all results of prior runs.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, done=0, mem_wen=0, mem_addr=0, mem_wdata=0, min_dist=16, max_dist=0, and clear all counters.
REQ-028 reset SHALL take priority over req in every state, including a reset mid-run (no further writes occur).
REQ-029 After reset deasserts, a run SHALL start only when req is sampled 0 in IDLE.

Verification
REQ-030 The bench SHALL run this case: all 32 words = 0x1234, req 1->0 -> mem[64]=0, mem[65]=0, done high after exactly 563 cycles.
REQ-031 The bench SHALL run this case: word0=0x0000, word5=0xFFFF, all others 0x0000 -> mem[64]=0, mem[65]=16.
REQ-032 The bench SHALL run this case: word k = 1<<(k mod 16), no duplicates among words 0..15 with 16..31 repeating -> min=0, max=2.
REQ-033 The bench SHALL run this case: reset pulsed for 1 cycle at cycle 300 of COMPARE -> done stays 0, no writes to 64/65, min_dist=16, max_dist=0.
REQ-034 The bench SHALL run this case: req raised during LOAD -> return to IDLE, no writes, done=0; a later req 1->0 -> a correct full run.
REQ-035 The bench SHALL run 10 random datasets and check mem[64]/[65] against a software model with strict-compare pairwise scan; all 10 SHALL match.

Source files
------------

// File: rtl/ham_minmax_engine.sv
// Loads N_WORDS 16-bit operands from byte memory, scans all pairs for min/max Hamming distance, writes both back.
// done rises 2*N_WORDS + N_WORDS*(N_WORDS-1)/2 + 3 cycles after the start edge; req=1 in LOAD/COMPARE aborts the run.
module ham_minmax_engine #(
  parameter int N_WORDS  = 32,
  parameter int MIN_ADDR = 64,
  parameter int MAX_ADDR = 65
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_wen,
  output logic [7:0] mem_wdata,
  output logic [4:0] min_dist,
  output logic [4:0] max_dist
);

  localparam int IW = (N_WORDS > 2) ? $clog2(N_WORDS) : 1;
  localparam logic [7:0] LAST_ADDR = 8'(2 * N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_COMPARE, S_WR_MIN, S_WR_MAX, S_DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_word [N_WORDS];
  logic [IW-1:0] r_i, r_j;
  logic        r_drain, r_dist_vld;
  logic [4:0]  r_dist, r_min, r_max;
  logic        r_done, r_wen;
  logic [7:0]  r_addr, r_wdata;
  logic [4:0]  r_min_dist, r_max_dist;

  logic [15:0] w_xor;
  logic [4:0]  w_pop, w_min_next, w_max_next;
  logic        w_last_pair;

  assign w_xor       = r_word[r_i] ^ r_word[r_j];
  assign w_last_pair = (r_i == IW'(N_WORDS - 2)) && (r_j == IW'(N_WORDS - 1));
  assign w_min_next  = (r_dist_vld && (r_dist < r_min)) ? r_dist : r_min;
  assign w_max_next  = (r_dist_vld && (r_dist > r_max)) ? r_dist : r_max;

  always_comb begin
    w_pop = 5'd0;
    for (int b = 0; b < 16; b++) w_pop = w_pop + {4'b0, w_xor[b]};
  end

  // Operand cache: even byte is the high half of the word.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      if (r_addr[0]) r_word[r_addr[IW:1]][7:0]  <= mem_rdata;
      else           r_word[r_addr[IW:1]][15:8] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= 8'd0;
      r_wdata    <= 8'd0;
      r_min_dist <= 5'd16;
      r_max_dist <= 5'd0;
      r_i        <= '0;
      r_j        <= '0;
      r_drain    <= 1'b0;
      r_dist_vld <= 1'b0;
      r_dist     <= 5'd0;
      r_min      <= 5'd16;
      r_max      <= 5'd0;
    end else begin
      r_wen      <= 1'b0;
      r_wdata    <= 8'd0;
      r_addr     <= 8'd0;
      r_dist_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (!req) begin
            r_state <= S_LOAD;
            r_min   <= 5'd16;
            r_max   <= 5'd0;
          end
        end
        S_LOAD: begin
          if (req) begin
            r_state <= S_IDLE;
          end else if (r_addr == LAST_ADDR) begin
            r_state <= S_COMPARE;
            r_i     <= '0;
            r_j     <= IW'(1);
            r_drain <= 1'b0;
          end else begin
            r_addr <= r_addr + 8'd1;
          end
        end
        S_COMPARE: begin
          if (req) begin
            r_state <= S_IDLE;
          end else begin
            // Distance is registered; the extra drain cycle folds in the last pair.
            r_min <= w_min_next;
            r_max <= w_max_next;
            if (!r_drain) begin
              r_dist     <= w_pop;
              r_dist_vld <= 1'b1;
              if (w_last_pair) begin
                r_drain <= 1'b1;
              end else if (r_j == IW'(N_WORDS - 1)) begin
                r_i <= r_i + IW'(1);
                r_j <= r_i + IW'(2);
              end else begin
                r_j <= r_j + IW'(1);
              end
            end else begin
              r_state <= S_WR_MIN;
              r_wen   <= 1'b1;
              r_addr  <= 8'(MIN_ADDR);
              r_wdata <= {3'b0, w_min_next};
            end
          end
        end
        S_WR_MIN: begin
          r_min_dist <= r_min;
          r_state    <= S_WR_MAX;
          r_wen      <= 1'b1;
          r_addr     <= 8'(MAX_ADDR);
          r_wdata    <= {3'b0, r_max};
        end
        S_WR_MAX: begin
          r_max_dist <= r_max;
          r_state    <= S_DONE;
          r_done     <= 1'b1;
        end
        S_DONE: begin
          if (req) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign done      = r_done;
  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign min_dist  = r_min_dist;
  assign max_dist  = r_max_dist;

endmodule

// File: tb/tb_ham_minmax_engine.sv
// Bench for ham_minmax_engine: byte memory model, pairwise-scan reference, directed and random datasets.
module tb_ham_minmax_engine;
  localparam int N       = 32;
  localparam int P       = N * (N - 1) / 2;
  localparam int RUN_CYC = 2 * N + P + 3;
  localparam int LIMIT   = 2000;

  logic       clk = 1'b0;
  logic       reset, req, done, mem_wen;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic [4:0] min_dist, max_dist;

  logic [7:0]  src [256];
  logic [15:0] tb_words [N];
  int checks = 0, errors = 0;
  int wr64 = 0, wr65 = 0, wr_other = 0;
  logic [7:0] last64 = 8'd0, last65 = 8'd0;
  int exp_min = 16, exp_max = 0;

  ham_minmax_engine #(.N_WORDS(N), .MIN_ADDR(64), .MAX_ADDR(65)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .min_dist(min_dist), .max_dist(max_dist)
  );

  always #5 clk = ~clk;
  assign mem_rdata = src[mem_addr];

  always @(posedge clk) begin
    if (mem_wen) begin
      if (mem_addr == 8'd64) begin wr64++; last64 = mem_wdata; end
      else if (mem_addr == 8'd65) begin wr65++; last65 = mem_wdata; end
      else wr_other++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(output int mn, output int mx);
    mn = 16;
    mx = 0;
    for (int i = 0; i < N - 1; i++)
      for (int j = i + 1; j < N; j++) begin
        int d;
        d = $countones(tb_words[i] ^ tb_words[j]);
        if (d < mn) mn = d;
        if (d > mx) mx = d;
      end
  endfunction

  task automatic load_words();
    for (int k = 0; k < N; k++) begin
      src[2*k]   = tb_words[k][15:8];
      src[2*k+1] = tb_words[k][7:0];
    end
  endtask

  task automatic run_full(input string name);
    int mn, mx, c, b64, b65, bo;
    model(mn, mx);
    load_words();
    b64 = wr64; b65 = wr65; bo = wr_other;
    req = 1'b0;
    step();
    c = 0;
    while (!done && c < LIMIT) begin step(); c++; end
    checks++;
    if (c !== RUN_CYC) begin errors++; $display("FAIL %s latency: got %0d cycles, expected %0d", name, c, RUN_CYC); end
    checks++;
    if (wr64 - b64 !== 1 || last64 !== 8'(mn)) begin
      errors++; $display("FAIL %s mem64: writes %0d value %0d, expected 1 write value %0d", name, wr64 - b64, last64, mn);
    end
    checks++;
    if (wr65 - b65 !== 1 || last65 !== 8'(mx)) begin
      errors++; $display("FAIL %s mem65: writes %0d value %0d, expected 1 write value %0d", name, wr65 - b65, last65, mx);
    end
    checks++;
    if (min_dist !== 5'(mn) || max_dist !== 5'(mx)) begin
      errors++; $display("FAIL %s dist regs: min %0d max %0d, expected %0d %0d", name, min_dist, max_dist, mn, mx);
    end
    checks++;
    if (wr_other !== bo) begin errors++; $display("FAIL %s stray writes: %0d, expected 0", name, wr_other - bo); end
    exp_min = mn;
    exp_max = mx;
    repeat (3) step();
    checks++;
    if (done !== 1'b1 || mem_addr !== 8'd0) begin
      errors++; $display("FAIL %s done hold: done %b addr %0d, expected 1 and 0", name, done, mem_addr);
    end
    req = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || mem_wen !== 1'b0) begin
      errors++; $display("FAIL %s release: done %b wen %b, expected 0 0", name, done, mem_wen);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1;
    step(); step();
    checks++;
    if (done !== 1'b0 || mem_wen !== 1'b0 || mem_addr !== 8'd0 || mem_wdata !== 8'd0 ||
        min_dist !== 5'd16 || max_dist !== 5'd0) begin
      errors++;
      $display("FAIL reset state: done %b wen %b addr %0d wdata %0d min %0d max %0d, expected 0 0 0 0 16 0",
               done, mem_wen, mem_addr, mem_wdata, min_dist, max_dist);
    end
    reset = 1'b0;
    repeat (4) step();
    checks++;
    if (done !== 1'b0 || mem_addr !== 8'd0) begin
      errors++; $display("FAIL idle hold: done %b addr %0d, expected 0 0", done, mem_addr);
    end
  endtask

  task automatic test_all_same();
    for (int k = 0; k < N; k++) tb_words[k] = 16'h1234;
    run_full("all_same");
  endtask

  task automatic test_single_ffff();
    for (int k = 0; k < N; k++) tb_words[k] = 16'h0000;
    tb_words[5] = 16'hFFFF;
    run_full("single_ffff");
  endtask

  task automatic test_onehot();
    for (int k = 0; k < N; k++) tb_words[k] = 16'(1 << (k % 16));
    run_full("onehot");
  endtask

  task automatic test_abort(input string name, input int delay);
    int b64, b65, bo;
    for (int k = 0; k < N; k++) tb_words[k] = 16'($urandom);
    load_words();
    b64 = wr64; b65 = wr65; bo = wr_other;
    req = 1'b0;
    step();
    repeat (delay) step();
    req = 1'b1;
    step();
    repeat (5) step();
    checks++;
    if (done !== 1'b0 || mem_addr !== 8'd0) begin
      errors++; $display("FAIL %s idle: done %b addr %0d, expected 0 0", name, done, mem_addr);
    end
    checks++;
    if (wr64 !== b64 || wr65 !== b65 || wr_other !== bo) begin
      errors++; $display("FAIL %s writes: %0d/%0d/%0d, expected none", name, wr64 - b64, wr65 - b65, wr_other - bo);
    end
    checks++;
    if (min_dist !== 5'(exp_min) || max_dist !== 5'(exp_max)) begin
      errors++; $display("FAIL %s kept regs: min %0d max %0d, expected %0d %0d", name, min_dist, max_dist, exp_min, exp_max);
    end
    for (int k = 0; k < N; k++) tb_words[k] = 16'($urandom) & 16'h0F3C;
    run_full({name, "_rerun"});
  endtask

  task automatic test_reset_mid_compare();
    int b64, b65, bo;
    bit seen_done;
    for (int k = 0; k < N; k++) tb_words[k] = 16'($urandom);
    load_words();
    b64 = wr64; b65 = wr65; bo = wr_other;
    req = 1'b0;
    step();
    repeat (2 * N + 300) step();
    reset = 1'b1; req = 1'b1;
    step();
    reset = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_reset done: rose, expected stays 0"); end
    checks++;
    if (wr64 !== b64 || wr65 !== b65 || wr_other !== bo) begin
      errors++; $display("FAIL mid_reset writes: %0d/%0d/%0d, expected none", wr64 - b64, wr65 - b65, wr_other - bo);
    end
    checks++;
    if (min_dist !== 5'd16 || max_dist !== 5'd0) begin
      errors++; $display("FAIL mid_reset regs: min %0d max %0d, expected 16 0", min_dist, max_dist);
    end
    exp_min = 16;
    exp_max = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      logic [15:0] mask;
      mask = (r % 3 == 0) ? 16'hFFFF : 16'($urandom);
      for (int k = 0; k < N; k++) tb_words[k] = 16'($urandom) & mask;
      run_full($sformatf("random%0d", r));
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) src[a] = 8'd0;
    reset = 1'b1;
    req = 1'b1;
    test_reset();
    test_all_same();
    test_single_ffff();
    test_onehot();
    test_abort("abort_load", 20);
    test_abort("abort_compare", 2 * N + 100);
    test_reset_mid_compare();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
